// File: rtl/da_mult_arbiter.sv
// Round-robin front end for one shared pipelined DA multiplier: grants one request per cycle,
// registers its operands and returns each product to its owner through a tag pipeline.
module da_mult_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ASIZE = 8,
  parameter int unsigned BSIZE = 8,
  parameter int unsigned LAT   = 3
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*ASIZE-1:0]         req_a,
  input  logic [NREQ*BSIZE-1:0]         req_b,
  output logic [NREQ-1:0]               rsp_valid,
  input  logic [NREQ-1:0]               rsp_ready,
  output logic [NREQ*(ASIZE+BSIZE)-1:0] rsp_data,
  output logic [ASIZE-1:0]              mul_a,
  output logic [BSIZE-1:0]              mul_b,
  input  logic [ASIZE+BSIZE-1:0]        mul_c,
  output logic                          busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = ASIZE + BSIZE;

  logic [NREQ-1:0]  pend_q, pend_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic [ASIZE-1:0] sel_a;
  logic [BSIZE-1:0] sel_b;

  // Entry 0 sits alongside mul_a/mul_b; entry LAT lines up with mul_c.
  logic [LAT:0]     tag_vld_q;
  logic [IW-1:0]    tag_idx_q [LAT+1];

  always_comb begin : arb
    int unsigned pos;
    pos       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = 32'(rr_ptr_q) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!grant_any && !rst && req_valid[pos[IW-1:0]] && !pend_q[pos[IW-1:0]]) begin
        grant_any              = 1'b1;
        grant[pos[IW-1:0]]     = 1'b1;
        grant_idx              = pos[IW-1:0];
      end
    end
  end

  always_comb begin : opsel
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*ASIZE +: ASIZE];
        sel_b = req_b[i*BSIZE +: BSIZE];
      end
    end
  end

  always_comb begin
    pend_d   = (pend_q & ~(rsp_valid & rsp_ready)) | grant;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign req_ready = grant;
  assign busy      = (|pend_q) | (|tag_vld_q);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      rr_ptr_q  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_vld_q <= '0;
      for (int unsigned s = 0; s <= LAT; s++) tag_idx_q[s] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      mul_a        <= sel_a;
      mul_b        <= sel_b;
      tag_vld_q[0] <= grant_any;
      tag_idx_q[0] <= grant_idx;
      for (int unsigned s = 1; s <= LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (tag_vld_q[LAT] && tag_idx_q[LAT] == IW'(j)) begin
          rsp_valid[j]           <= 1'b1;
          rsp_data[j*PW +: PW]   <= mul_c;
        end else if (rsp_valid[j] && rsp_ready[j]) begin
          rsp_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule
